// File: rtl/truth_table_pkg.sv
// ---------------------------------------------------------------------------
// truth_table_pkg
// Shared definitions for the truth-table sweeper: FSM state encoding and the
// golden table of the default gate stage, Z = (A & B) ^ ~(B & C).
// ---------------------------------------------------------------------------
package truth_table_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_t;

    // Bit i is the required Z for input pattern i = {A, B, C}.
    localparam logic [7:0] EXPECTED_AND_NAND_XOR = 8'hB7;

endpackage

// File: rtl/settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
// Counts the clocks a stimulus pattern has been held. The last pulse marks
// the clock on which the stage output is sampled.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous reset, active low
//   clr    in   restart the count from zero
//   en     in   advance the count this clock
//   last   out  count == HOLD_CYCLES-1
// ---------------------------------------------------------------------------
module settle_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_VAL = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign last = (count_q == LAST_VAL);

    // Wrapping on last keeps the counter at zero between patterns, so each
    // new pattern gets a full hold window without an extra clear.
    always_comb begin
        count_d = count_q;
        if (clr || last) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
// Drives every input pattern 0..2^N_IN-1 into a combinational gate stage,
// holds each one HOLD_CYCLES clocks, samples the stage output on the last
// clock, and compares the captured table against EXPECTED.
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   synchronous reset, active low
//   start         in   request a sweep; accepted only in IDLE
//   z_in          in   stage output (combinational from abc_out)
//   abc_out       out  registered stimulus pattern, A = MSB
//   busy          out  high whenever not IDLE
//   done          out  one-cycle pulse in the DONE state
//   table_out     out  captured table, bit i = z_in for pattern i
//   pass          out  table_out == EXPECTED, valid from done
//   mismatch_cnt  out  number of bits where table_out != EXPECTED
// ---------------------------------------------------------------------------
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int                    N_IN        = 3,
    parameter int                    HOLD_CYCLES = 4,
    parameter logic [2**N_IN-1:0]    EXPECTED    = EXPECTED_AND_NAND_XOR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 z_in,
    output logic [N_IN-1:0]      abc_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_cnt
);

    localparam logic [N_IN-1:0] IDX_MAX = '1;

    sweep_state_t          state_q, state_d;
    logic [N_IN-1:0]       idx_q, idx_d;
    logic [N_IN-1:0]       abc_q, abc_d;
    logic [2**N_IN-1:0]    table_q, table_d;
    logic [N_IN:0]         mis_q, mis_d;
    logic                  pass_q, pass_d;

    logic                  start_acc;
    logic                  hold_last;

    assign start_acc = (state_q == ST_IDLE) && start;

    settle_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_acc),
        .en    (state_q == ST_DRIVE),
        .last  (hold_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_DRIVE;
            ST_DRIVE: if (hold_last && (idx_q == IDX_MAX)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    // Pattern index and capture datapath
    always_comb begin
        idx_d   = idx_q;
        table_d = table_q;
        mis_d   = mis_q;
        pass_d  = pass_q;

        if (start_acc) begin
            idx_d   = '0;
            table_d = '0;
            mis_d   = '0;
            pass_d  = 1'b0;
        end

        if ((state_q == ST_DRIVE) && hold_last) begin
            table_d[idx_q] = z_in;
            if (z_in != EXPECTED[idx_q]) begin
                mis_d = mis_q + (N_IN+1)'(1);
            end
            // pass is decided on the edge of the final sample so it is
            // already valid while done is high.
            if (idx_q == IDX_MAX) begin
                pass_d = (mis_d == '0);
            end else begin
                idx_d = idx_q + N_IN'(1);
            end
        end

        // Registered so the pattern changes only at hold-window boundaries.
        abc_d = (state_d == ST_DRIVE) ? idx_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            abc_q   <= '0;
            table_q <= '0;
            mis_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            abc_q   <= abc_d;
            table_q <= table_d;
            mis_q   <= mis_d;
            pass_q  <= pass_d;
        end
    end

    assign abc_out      = abc_q;
    assign table_out    = table_q;
    assign mismatch_cnt = mis_q;
    assign pass         = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sel;        // 0: HOLD_CYCLES=4 instance, 1: HOLD_CYCLES=1 instance
    logic [7:0] flip;       // per-pattern fault injected into the gate stage
    logic [7:0] golden;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instance with default hold time
    logic [2:0] abc4;
    logic       busy4, done4, pass4, z4;
    logic [7:0] tbl4;
    logic [3:0] mis4;

    // Instance with single-cycle hold
    logic [2:0] abc1;
    logic       busy1, done1, pass1, z1;
    logic [7:0] tbl1;
    logic [3:0] mis1;

    function automatic logic gate(input logic [2:0] p);
        logic a, b, c;
        {a, b, c} = p;
        return (a & b) ^ ~(b & c);
    endfunction

    assign z4 = gate(abc4) ^ flip[abc4];
    assign z1 = gate(abc1) ^ flip[abc1];

    truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .z_in(z4),
        .abc_out(abc4), .busy(busy4), .done(done4), .table_out(tbl4),
        .pass(pass4), .mismatch_cnt(mis4)
    );

    truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .z_in(z1),
        .abc_out(abc1), .busy(busy1), .done(done1), .table_out(tbl1),
        .pass(pass1), .mismatch_cnt(mis1)
    );

    // Selected-instance view
    logic [2:0] abc;
    logic       busy, done, pass;
    logic [7:0] tbl;
    logic [3:0] mis;
    assign abc  = sel ? abc1  : abc4;
    assign busy = sel ? busy1 : busy4;
    assign done = sel ? done1 : done4;
    assign pass = sel ? pass1 : pass4;
    assign tbl  = sel ? tbl1  : tbl4;
    assign mis  = sel ? mis1  : mis4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One full sweep starting from an IDLE cycle. The model: pattern k is on
    // abc for clocks k*h+1..(k+1)*h after the accepting edge, is captured at
    // the end of that window, and done follows the last capture by one edge.
    task automatic sweep(input int h, input logic [7:0] f, input bit glitch, input bit keep);
        logic [7:0] want_tbl, part;
        int         want_mis, part_mis, k, glitch_c;
        want_tbl = golden ^ f;
        want_mis = $countones(f);
        flip     = f;
        glitch_c = (h > 1) ? $urandom_range(1, 8*h-1) : $urandom_range(1, 7);
        start    = 1'b1;
        @(posedge clk); #1;
        if (!keep) start = 1'b0;
        for (int c = 0; c <= 8*h; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            k = c / h;
            part = '0;
            part_mis = 0;
            for (int j = 0; j < k; j++) begin
                part[j]  = want_tbl[j];
                part_mis += int'(f[j]);
            end
            check("busy", busy, 1);
            check("done", done, (c == 8*h));
            if (c < 8*h) check("abc", abc, k);
            check("table", tbl, part);
            check("mis", mis, part_mis);
            check("pass", pass, (c == 8*h) && (want_mis == 0));
            if (glitch) start = (c == glitch_c || c == 8*h) ? 1'b1 : keep;
        end
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_abc", abc, 0);
        check("hold_table", tbl, want_tbl);
        check("hold_mis", mis, want_mis);
        check("hold_pass", pass, want_mis == 0);
        if (!keep) start = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("gap_busy", busy, 0);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_abc"}, abc, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_table"}, tbl, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_mis"}, mis, 0);
    endtask

    initial begin
        for (int p = 0; p < 8; p++) golden[p] = gate(3'(p));
        rst_n = 1'b0;
        start = 1'b0;
        sel   = 1'b0;
        flip  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("rst4");
        sel = 1'b1; #1;
        check_cleared("rst1");
        sel = 1'b0;
        rst_n = 1'b1;
        idle_gap(2);

        // Correct stage, then constant-0 stage, then ignored start pulses
        sweep(4, 8'h00, 0, 0);
        idle_gap(1);
        sweep(4, golden, 0, 0);
        idle_gap(2);
        sweep(4, 8'h00, 1, 0);
        idle_gap(1);

        // Reset in the middle of a sweep
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("pre_rst_table", tbl, golden & 8'h0F);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_cleared("midrst");
        idle_gap(1);
        sweep(4, 8'h00, 0, 0);

        // Randomized stage faults, gaps and stray start pulses
        for (int r = 0; r < 5; r++) begin
            idle_gap($urandom_range(0, 3));
            sweep(4, (r == 0) ? 8'h01 : 8'($urandom), 1'($urandom), 0);
        end

        // Start held high: back-to-back sweeps
        idle_gap(1);
        for (int r = 0; r < 3; r++) sweep(4, 8'h00, 0, 1);
        idle_gap(2);

        // Single-cycle hold instance
        sel = 1'b1;
        idle_gap(1);
        sweep(1, 8'h00, 0, 0);
        for (int r = 0; r < 4; r++) begin
            idle_gap($urandom_range(0, 2));
            sweep(1, 8'($urandom), 1'($urandom), 0);
        end
        idle_gap(1);
        for (int r = 0; r < 2; r++) sweep(1, 8'h00, 0, 1);
        idle_gap(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
